snax_hwpe_tcdm_arbiter: RTL

//  Shares one reqrsp TCDM port between NumPorts HWPE streamer TCDM masters (e.g. MAC A/B/C streams).

---
 rtl/snax_hwpe_tcdm_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/snax_hwpe_tcdm_arbiter.sv
// Round-robin arbiter that funnels several HWPE streamer TCDM masters into
// one reqrsp TCDM port. The grant stays locked on one master while the memory
// stalls. Accepted requests are recorded in order, so that in-order responses
// can be routed back to the master that issued them.
module snax_hwpe_tcdm_arbiter #(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned RspFifoDepth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPorts-1:0]       hwpe_req_i,
  output logic [NumPorts-1:0]       hwpe_gnt_o,
  input  logic [NumPorts*32-1:0]    hwpe_add_i,
  input  logic [NumPorts-1:0]       hwpe_wen_i,
  input  logic [NumPorts*32-1:0]    hwpe_data_i,
  output logic [31:0]               hwpe_rdata_o,
  output logic [NumPorts-1:0]       hwpe_rvalid_o,
  output logic                      tcdm_q_valid_o,
  input  logic                      tcdm_q_ready_i,
  output logic [AddrWidth-1:0]      tcdm_q_addr_o,
  output logic                      tcdm_q_write_o,
  output logic [DataWidth-1:0]      tcdm_q_data_o,
  output logic [DataWidth/8-1:0]    tcdm_q_strb_o,
  input  logic                      tcdm_p_valid_i,
  input  logic [DataWidth-1:0]      tcdm_p_data_i,
  output logic                      rsp_err_o
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  typedef struct packed {
    logic [PortW-1:0] port;
    logic             is_read;
    logic             add2;
  } ord_t;

  state_e           state_q, state_d;
  logic [PortW-1:0] rr_q, rr_d;
  logic [PortW-1:0] hold_q, hold_d;
  logic [PortW-1:0] win_idx, sel;
  logic             any_req;
  logic             q_valid, push, pop;
  logic             fifo_full, fifo_empty;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             err_q;
  ord_t             mem_q [RspFifoDepth];
  ord_t             head, push_entry;
  logic [31:0]      sel_add, sel_data;
  logic             sel_wen;
  logic             unused_add_bits;

  // Increment a port index, wrapping at NumPorts.
  function automatic logic [PortW-1:0] next_port(input logic [PortW-1:0] p);
    logic [PortW:0] n;
    n = {1'b0, p} + (PortW+1)'(1);
    if (n >= (PortW+1)'(NumPorts)) n = '0;
    return n[PortW-1:0];
  endfunction

  assign fifo_full  = (cnt_q == CntW'(RspFifoDepth));
  assign fifo_empty = (cnt_q == '0);

  // Round-robin search: first requesting master at or above the rr pointer.
  always_comb begin
    logic [PortW:0] k;
    k       = '0;
    any_req = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NumPorts; i++) begin
      k = {1'b0, rr_q} + (PortW+1)'(i);
      if (k >= (PortW+1)'(NumPorts)) k = k - (PortW+1)'(NumPorts);
      if (!any_req && hwpe_req_i[k[PortW-1:0]]) begin
        any_req = 1'b1;
        win_idx = k[PortW-1:0];
      end
    end
  end

  // Arbitration FSM: 0-cycle grant when ready, otherwise lock the winner.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    hold_d     = hold_q;
    sel        = win_idx;
    q_valid    = 1'b0;
    push       = 1'b0;
    hwpe_gnt_o = '0;
    unique case (state_q)
      IDLE: begin
        // Fullness is sampled before any same-cycle pop.
        if (any_req && !fifo_full) begin
          q_valid = 1'b1;
          if (tcdm_q_ready_i) begin
            push                = 1'b1;
            hwpe_gnt_o[win_idx] = 1'b1;
            rr_d                = next_port(win_idx);
          end else begin
            hold_d  = win_idx;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Entry into HOLD guaranteed a free slot; only pops happen meanwhile.
        sel     = hold_q;
        q_valid = 1'b1;
        if (tcdm_q_ready_i) begin
          push               = 1'b1;
          hwpe_gnt_o[hold_q] = 1'b1;
          rr_d               = next_port(hold_q);
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload of the selected master.
  always_comb begin
    sel_add  = '0;
    sel_data = '0;
    sel_wen  = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (sel == PortW'(i)) begin
        sel_add  = hwpe_add_i[i*32 +: 32];
        sel_data = hwpe_data_i[i*32 +: 32];
        sel_wen  = hwpe_wen_i[i];
      end
    end
  end

  // Byte offset bits are dropped by the double-word alignment.
  assign unused_add_bits = ^sel_add[1:0];

  assign tcdm_q_valid_o = q_valid;
  assign tcdm_q_addr_o  = AddrWidth'({sel_add[31:3], 3'b000});
  assign tcdm_q_write_o = ~sel_wen;
  assign tcdm_q_data_o  = DataWidth'({sel_data, sel_data});
  assign tcdm_q_strb_o  = sel_wen ? '1 : (sel_add[2] ? 8'hF0 : 8'h0F);

  assign push_entry = '{port: sel, is_read: sel_wen, add2: sel_add[2]};
  assign head       = mem_q[rd_ptr_q];
  assign pop        = tcdm_p_valid_i && !fifo_empty;

  // Route a read response to its owner; write responses are dropped.
  always_comb begin
    hwpe_rvalid_o = '0;
    hwpe_rdata_o  = '0;
    if (pop && head.is_read) begin
      hwpe_rvalid_o[head.port] = 1'b1;
      hwpe_rdata_o = head.add2 ? tcdm_p_data_i[63:32] : tcdm_p_data_i[31:0];
    end
  end

  assign rsp_err_o = err_q;

  // Control state: FSM, rr pointer, order FIFO pointers and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (tcdm_p_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // Order FIFO storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
